// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the DMA datapath:
//   AXI_LEN_BC_WIDTH  width of a per-request byte count (covers 0..4096)
//   AXI_4K_BOUNDARY   size of the address window a burst may not cross
//   axi_resp_e        AXI response codes
//   axi_dma_seq_state_e  state encoding of the request sequencer
//   axi_resp_is_err   true for SLVERR / DECERR
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_LEN_BC_WIDTH = 13;
    localparam int AXI_4K_BOUNDARY  = 4096;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } axi_dma_seq_state_e;

    function automatic logic axi_resp_is_err(input axi_resp_e r);
        return (r == AXI_RESP_SLVERR) || (r == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_dma_req_if.sv
// ---------------------------------------------------------------------------
// axi_dma_req_if
// Burst request / response channel between a DMA sequencer and an AXI manager.
//   valid/ready       request handshake
//   addr, byte_len    first byte address and byte count of the burst
//   fixed             FIXED burst (address does not advance)
//   lock              exclusive access request
//   resp_valid, resp  one response per accepted request
// Modports: src (sequencer side), dst (manager side).
// ---------------------------------------------------------------------------
interface axi_dma_req_if #(
    parameter int AW   = 32,
    parameter int BC_W = axi_pkg::AXI_LEN_BC_WIDTH
) ();
    import axi_pkg::*;

    logic            valid;
    logic            ready;
    logic [AW-1:0]   addr;
    logic [BC_W-1:0] byte_len;
    logic            fixed;
    logic            lock;
    logic            resp_valid;
    axi_resp_e       resp;

    modport src (
        output valid, addr, byte_len, fixed, lock,
        input  ready, resp_valid, resp
    );

    modport dst (
        input  valid, addr, byte_len, fixed, lock,
        output ready, resp_valid, resp
    );

endinterface

// File: rtl/axi_dma_chunk_calc.sv
// ---------------------------------------------------------------------------
// axi_dma_chunk_calc
// Combinational size of the next burst:
//   chunk = min(remaining, max_bytes, 4096 - addr_off)
// With fixed=1 the 4 KB term is dropped (the address never advances).
// Ports:
//   remaining  [LEN_W]  bytes still to transfer
//   addr_off   [12]     address bits [11:0] of the next burst
//   max_bytes  [BC_W]   per-burst byte limit (nonzero)
//   fixed      [1]      FIXED burst, bypass the 4 KB limit
//   chunk      [BC_W]   resulting burst byte count
// LEN_W must be at least BC_W.
// ---------------------------------------------------------------------------
module axi_dma_chunk_calc
    import axi_pkg::*;
#(
    parameter int LEN_W = 32,
    parameter int BC_W  = AXI_LEN_BC_WIDTH
) (
    input  logic [LEN_W-1:0] remaining,
    input  logic [11:0]      addr_off,
    input  logic [BC_W-1:0]  max_bytes,
    input  logic             fixed,
    output logic [BC_W-1:0]  chunk
);

    // One spare bit so 4096 and the full byte count never wrap.
    localparam int CW = LEN_W + 1;

    logic [CW-1:0] rem_x;
    logic [CW-1:0] max_x;
    logic [CW-1:0] bnd_x;
    logic [CW-1:0] min_rm;
    logic          rem_lt_max;
    logic          use_bnd;

    always_comb begin
        rem_x      = {1'b0, remaining};
        max_x      = CW'(max_bytes);
        bnd_x      = CW'(AXI_4K_BOUNDARY) - CW'(addr_off);
        rem_lt_max = (rem_x < max_x);
        min_rm     = rem_lt_max ? rem_x : max_x;
        use_bnd    = !fixed && (bnd_x < min_rm);

        // Every candidate chosen here is <= max_bytes, so it fits in BC_W.
        if (use_bnd) begin
            chunk = bnd_x[BC_W-1:0];
        end else if (rem_lt_max) begin
            chunk = remaining[BC_W-1:0];
        end else begin
            chunk = max_bytes;
        end
    end

endmodule

// File: rtl/axi_dma_req_seq.sv
// ---------------------------------------------------------------------------
// axi_dma_req_seq
// Splits one DMA descriptor (start address, byte count, fixed flag) into
// burst requests that respect a per-burst byte limit and the AXI 4 KB rule,
// tracks outstanding requests and collects their responses.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, captures the descriptor when idle
//   start_addr        first byte address
//   total_bytes       transfer size in bytes (0 completes with no request)
//   fixed_in          FIXED burst, address does not advance
//   max_bytes         per-request byte limit, sampled at start
//   abort             stop raising new requests, drain outstanding ones
//   req               request/response channel (src side)
//   busy              descriptor in progress (any state but IDLE)
//   done              one-cycle completion pulse
//   error             sticky SLVERR/DECERR flag, cleared by the next start
//   outst_cnt         requests accepted but not yet answered
// Build option: AXI_DMA_REQ_SEQ_ERR_STOP_EN -- when defined, the first error
// response acts like abort; otherwise errors are only recorded.
// ---------------------------------------------------------------------------
module axi_dma_req_seq
    import axi_pkg::*;
#(
    parameter int AW        = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_OUTST = 4,
    parameter int BC_W      = AXI_LEN_BC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [AW-1:0]                  start_addr,
    input  logic [LEN_W-1:0]               total_bytes,
    input  logic                           fixed_in,
    input  logic [BC_W-1:0]                max_bytes,
    input  logic                           abort,
    axi_dma_req_if.src                     req,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    axi_dma_seq_state_e state, state_d;

    logic [AW-1:0]    cur_addr, cur_addr_d;
    logic [LEN_W-1:0] remaining, remaining_d;
    logic             fixed_q, fixed_d;
    logic [BC_W-1:0]  max_q, max_d;
    logic             abort_q, abort_d;
    logic             error_d;
    logic [OW-1:0]    outst_d;
    logic             done_q, done_d;

    logic             valid_q, valid_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BC_W-1:0]  len_q, len_d;
    logic             rfixed_q, rfixed_d;

    logic             hs;
    logic             resp_err;
    logic             stop;
    logic             at_boundary;
    logic [LEN_W-1:0] rem_after;
    logic [AW-1:0]    addr_after;
    logic [BC_W-1:0]  chunk;

    // Descriptor state as it will be once this cycle's handshake (if any)
    // is accounted for; the next chunk is sized from these so a new request
    // can follow a handshake immediately.
    always_comb begin
        hs         = valid_q && req.ready;
        resp_err   = req.resp_valid && axi_resp_is_err(req.resp);
        rem_after  = hs ? (remaining - LEN_W'(len_q)) : remaining;
        addr_after = (hs && !fixed_q) ? (cur_addr + AW'(len_q)) : cur_addr;
        // A request boundary: nothing pending, or the pending one just left.
        at_boundary = !valid_q || hs;
`ifdef AXI_DMA_REQ_SEQ_ERR_STOP_EN
        stop = abort_q || abort || error || resp_err;
`else
        stop = abort_q || abort;
`endif
    end

    axi_dma_chunk_calc #(
        .LEN_W (LEN_W),
        .BC_W  (BC_W)
    ) u_chunk_calc (
        .remaining (rem_after),
        .addr_off  (addr_after[11:0]),
        .max_bytes (max_q),
        .fixed     (fixed_q),
        .chunk     (chunk)
    );

    // Outstanding count: a handshake and a response in the same cycle cancel.
    // A response with nothing outstanding saturates at zero.
    always_comb begin
        unique case ({hs, req.resp_valid})
            2'b10:   outst_d = outst_cnt + 1'b1;
            2'b01:   outst_d = (outst_cnt == '0) ? '0 : outst_cnt - 1'b1;
            default: outst_d = outst_cnt;
        endcase
    end

    // NOTE: every signal written here is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        cur_addr_d  = cur_addr;
        remaining_d = remaining;
        fixed_d     = fixed_q;
        max_d       = max_q;
        abort_d     = abort_q;
        error_d     = error || resp_err;
        done_d      = 1'b0;
        // A presented request holds addr/len/fixed until it is accepted.
        valid_d     = valid_q && !hs;
        addr_d      = addr_q;
        len_d       = len_q;
        rfixed_d    = rfixed_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = start_addr;
                    remaining_d = total_bytes;
                    fixed_d     = fixed_in;
                    max_d       = max_bytes;
                    abort_d     = 1'b0;
                    error_d     = 1'b0;
                    state_d     = (total_bytes == '0) ? DONE : ISSUE;
                end
            end

            ISSUE: begin
                remaining_d = rem_after;
                cur_addr_d  = addr_after;
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (at_boundary) begin
                    if ((rem_after == '0) || stop) begin
                        state_d = DRAIN;
                    end else if (outst_d < OW'(MAX_OUTST)) begin
                        valid_d  = 1'b1;
                        addr_d   = addr_after;
                        len_d    = chunk;
                        rfixed_d = fixed_q;
                    end
                end
            end

            DRAIN: begin
                if (outst_cnt == '0) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            fixed_q   <= 1'b0;
            max_q     <= '0;
            abort_q   <= 1'b0;
            error     <= 1'b0;
            outst_cnt <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            rfixed_q  <= 1'b0;
        end else begin
            state     <= state_d;
            cur_addr  <= cur_addr_d;
            remaining <= remaining_d;
            fixed_q   <= fixed_d;
            max_q     <= max_d;
            abort_q   <= abort_d;
            error     <= error_d;
            outst_cnt <= outst_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rfixed_q  <= rfixed_d;
        end
    end

    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign req.valid    = valid_q;
    assign req.addr     = addr_q;
    assign req.byte_len = len_q;
    assign req.fixed    = rfixed_q;
    assign req.lock     = 1'b0;

    // A response with nothing outstanding is a protocol violation upstream.
    a_resp_without_outst: assert property (
        @(posedge clk) disable iff (!rst_n) req.resp_valid |-> (outst_cnt != '0)
    );

endmodule
